// File: rtl/dmem_port_arbiter_if.sv
// Signal bundle between the data-memory port B arbiter, its two
// requesters (CPU LSU, debug loader) and the BRAM port B pins.
interface dmem_port_arbiter_if;
  logic        c_req;
  logic [3:0]  c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_gnt;
  logic        c_rvalid;
  logic [31:0] c_rdata;
  logic        cpu_stall;
  logic        d_req;
  logic        d_lock;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        enb;
  logic [3:0]  web;
  logic [31:0] addrb;
  logic [31:0] dib;
  logic [31:0] dob;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_lock, d_we, d_addr, d_wdata,
    input  dob,
    output c_gnt, c_rvalid, c_rdata, cpu_stall,
    output d_gnt, d_rvalid, d_rdata,
    output enb, web, addrb, dib
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_lock, d_we, d_addr, d_wdata,
    output dob,
    input  c_gnt, c_rvalid, c_rdata, cpu_stall,
    input  d_gnt, d_rvalid, d_rdata,
    input  enb, web, addrb, dib
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Port B arbiter: CPU LSU vs debug loader, round-robin with debug
// burst lock, CPU starvation guard and 1-cycle read-data steering.
module dmem_port_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int RD_LAT   = 1
) (
  input logic             clk,
  input logic             rst_n,
  dmem_port_arbiter_if.slave bus
);

  if (RD_LAT != 1) begin : g_bad_lat
    $error("dmem_port_arbiter: only RD_LAT=1 is supported");
  end
  if (MAX_WAIT < 1) begin : g_bad_wait
    $error("dmem_port_arbiter: MAX_WAIT must be >= 1");
  end

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  logic          last_owner;
  logic          lock_own;
  logic [WW-1:0] wait_cnt;
  logic          rd_pend;
  logic          rd_tag;

  logic pick_c;
  logic c_gnt;
  logic d_gnt;
  logic stall;
  logic rd_issue;

  // Tie-break when both request; ignored otherwise.
  always_comb begin
    pick_c = 1'b0;
    if (wait_cnt == WMAX)
      pick_c = 1'b1;
    else if (lock_own && bus.d_lock)
      pick_c = 1'b0;
    else
      pick_c = last_owner;
  end

  assign c_gnt = bus.c_req & (~bus.d_req | pick_c);
  assign d_gnt = bus.d_req & (~bus.c_req | ~pick_c);
  assign stall = bus.c_req & ~c_gnt;

  assign rd_issue = (c_gnt && bus.c_we == 4'd0)
                  | (d_gnt && bus.d_we == 4'd0);

  assign bus.c_gnt     = c_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.cpu_stall = stall;
  assign bus.enb       = c_gnt | d_gnt;

  always_comb begin
    bus.web   = 4'd0;
    bus.addrb = 32'd0;
    bus.dib   = 32'd0;
    unique case (1'b1)
      c_gnt: begin
        bus.web   = bus.c_we;
        bus.addrb = bus.c_addr;
        bus.dib   = bus.c_wdata;
      end
      d_gnt: begin
        bus.web   = bus.d_we;
        bus.addrb = bus.d_addr;
        bus.dib   = bus.d_wdata;
      end
      default: ;
    endcase
  end

  assign bus.c_rvalid = rd_pend & ~rd_tag;
  assign bus.d_rvalid = rd_pend & rd_tag;
  assign bus.c_rdata  = bus.c_rvalid ? bus.dob : 32'd0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.dob : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= 1'b1;
      lock_own   <= 1'b0;
      wait_cnt   <= '0;
      rd_pend    <= 1'b0;
      rd_tag     <= 1'b0;
    end else begin
      if (c_gnt || d_gnt)
        last_owner <= d_gnt;
      lock_own <= d_gnt & bus.d_lock;
      if (!stall)
        wait_cnt <= '0;
      else if (wait_cnt != WMAX)
        wait_cnt <= wait_cnt + 1'b1;
      rd_pend <= rd_issue;
      if (rd_issue)
        rd_tag <= d_gnt;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios then random traffic
// against a rule-level model with a BRAM model behind port B.
module tb_dmem_port_arbiter;

  localparam int MAX_WAIT = 8;

  logic clk;
  logic rst_n;
  dmem_port_arbiter_if bus();

  dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .RD_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (bus.enb) begin
      if (bus.web == 4'd0)
        bus.dob <= mem[bus.addrb[9:2]];
      else
        for (int b = 0; b < 4; b++)
          if (bus.web[b])
            mem[bus.addrb[9:2]][8*b +: 8] <= bus.dib[8*b +: 8];
    end
  end

  int n_chk;
  int n_fail;

  // model state
  bit          m_last;
  bit          m_lock;
  int          m_denied;
  bit          m_rv_c;
  bit          m_rv_d;
  logic [31:0] m_rdat;
  int          run;

  logic        o_cg, o_dg, o_stall, o_crv, o_drv, o_enb;
  logic [3:0]  o_web;
  logic [31:0] o_dib, o_crd, o_drd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last   = 1'b1;
    m_lock   = 1'b0;
    m_denied = 0;
    m_rv_c   = 1'b0;
    m_rv_d   = 1'b0;
    m_rdat   = 32'd0;
    run      = 0;
  endtask

  task automatic step(
    input logic cr, input logic [3:0] cw,
    input logic [31:0] ca, input logic [31:0] cd,
    input logic dr, input logic dl, input logic [3:0] dw,
    input logic [31:0] da, input logic [31:0] dd);
    bit          gc, gd;
    logic [3:0]  ewe;
    logic [31:0] ea, ed, rd;
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.d_req = dr; bus.d_lock = dl; bus.d_we = dw;
    bus.d_addr = da; bus.d_wdata = dd;
    #1;
    gc = 1'b0;
    gd = 1'b0;
    if (cr && dr) begin
      if (m_denied >= MAX_WAIT)  gc = 1'b1;
      else if (m_lock && dl)     gd = 1'b1;
      else if (m_last)           gc = 1'b1;
      else                       gd = 1'b1;
    end else begin
      gc = cr;
      gd = dr;
    end
    ewe = gc ? cw : (gd ? dw : 4'd0);
    ea  = gc ? ca : (gd ? da : 32'd0);
    ed  = gc ? cd : (gd ? dd : 32'd0);
    rd  = mem[ea[9:2]];
    o_cg = bus.c_gnt;   o_dg = bus.d_gnt;
    o_stall = bus.cpu_stall; o_enb = bus.enb;
    o_web = bus.web;    o_dib = bus.dib;
    o_crv = bus.c_rvalid; o_drv = bus.d_rvalid;
    o_crd = bus.c_rdata;  o_drd = bus.d_rdata;
    chk("c_gnt", {31'd0, o_cg}, {31'd0, gc});
    chk("d_gnt", {31'd0, o_dg}, {31'd0, gd});
    chk("one_gnt", {31'd0, o_cg & o_dg}, 32'd0);
    chk("cpu_stall", {31'd0, o_stall}, {31'd0, cr & ~gc});
    chk("enb", {31'd0, o_enb}, {31'd0, gc | gd});
    chk("web", {28'd0, o_web}, {28'd0, ewe});
    chk("addrb", bus.addrb, ea);
    chk("dib", o_dib, ed);
    chk("c_rvalid", {31'd0, o_crv}, {31'd0, m_rv_c});
    chk("d_rvalid", {31'd0, o_drv}, {31'd0, m_rv_d});
    chk("c_rdata", o_crd, m_rv_c ? m_rdat : 32'd0);
    chk("d_rdata", o_drd, m_rv_d ? m_rdat : 32'd0);
    run = o_stall ? run + 1 : 0;
    chk("deny_bound", {31'd0, run <= MAX_WAIT}, 32'd1);
    @(posedge clk);
    m_rv_c = gc && cw == 4'd0;
    m_rv_d = gd && dw == 4'd0;
    m_rdat = rd;
    if (gc || gd) m_last = gd;
    m_lock = gd && dl;
    if (cr && !gc)
      m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
    else
      m_denied = 0;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.d_req = 0; bus.d_lock = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] raddr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return {22'd0, w, 2'b00};
  endfunction

  function automatic logic [3:0] rwe();
    return ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom);
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    bus.dob = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    @(negedge clk);

    // reset state
    chk("rst_enb", {31'd0, bus.enb}, 32'd0);
    chk("rst_c_rvalid", {31'd0, bus.c_rvalid}, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);

    // 1: CPU-only read
    step(1, 4'd0, 32'h10, 0, 0, 0, 0, 0, 0);
    chk("t1_gnt", {31'd0, o_cg}, 32'd1);
    chk("t1_stall", {31'd0, o_stall}, 32'd0);
    idle();
    chk("t1_rvalid", {31'd0, o_crv}, 32'd1);
    chk("t1_rdata", o_crd, mem[4]);

    // 2: tie after reset alternates starting with CPU
    do_reset();
    @(negedge clk);
    step(1, 0, 32'h40, 0, 1, 0, 0, 32'h44, 0);
    chk("t2_c0", {31'd0, o_cg}, 32'd1);
    step(1, 0, 32'h40, 0, 1, 0, 0, 32'h44, 0);
    chk("t2_d1", {31'd0, o_dg}, 32'd1);
    chk("t2_crv1", {31'd0, o_crv}, 32'd1);
    step(1, 0, 32'h40, 0, 1, 0, 0, 32'h44, 0);
    chk("t2_c2", {31'd0, o_cg}, 32'd1);
    chk("t2_drv2", {31'd0, o_drv}, 32'd1);
    idle();
    chk("t2_crv3", {31'd0, o_crv}, 32'd1);

    // 3: debug lock vs starvation guard
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      step(1, 0, 32'h80, 0, 1, 1, 0, 32'h84, 0);
      chk($sformatf("t3_dgnt%0d", k), {31'd0, o_dg},
          {31'd0, (k >= 1 && k <= 8) || k >= 10});
    end
    idle();

    // 4: CPU byte store on lane 2
    step(1, 4'b0100, 32'h20, 32'h00AB0000, 0, 0, 0, 0, 0);
    chk("t4_web", {28'd0, o_web}, 32'h4);
    chk("t4_dib", o_dib, 32'h00AB0000);
    idle();
    chk("t4_norv", {31'd0, o_crv}, 32'd0);
    chk("t4_mem", mem[8] & 32'h00FF0000, 32'h00AB0000);

    // 5: reset while a debug read is in flight
    step(0, 0, 0, 0, 1, 0, 0, 32'hC0, 0);
    chk("t5_dgnt", {31'd0, o_dg}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_drv", {31'd0, bus.d_rvalid}, 32'd0);
    chk("t5_rst_drd", bus.d_rdata, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("t5_after_drv", {31'd0, o_drv}, 32'd0);
    step(1, 0, 32'h4, 0, 1, 0, 0, 32'h8, 0);
    chk("t5_tie_cpu", {31'd0, o_cg}, 32'd1);

    // 6: random traffic
    for (int n = 0; n < 10000; n++) begin
      step($urandom_range(0, 3) != 0, rwe(), raddr(), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           rwe(), raddr(), $urandom);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
